iob_cpu_bus_arbiter: RTL and testbench
======================================

Name: iob_cpu_bus_arbiter

Overview:
- Two-master, one-slave arbiter on the native iob request/response bus.
- Sits directly downstream of the CPU wrapper. It merges the instruction bus (master 0) and the data bus (master 1) into one memory/interconnect port.
- Holds each grant until the slave returns ready, and routes the response back to the granted master only.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be a multiple of 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  REQ_W  ibus request {valid, addr[ADDR_W-1:0], wdata[DATA_W-1:0], wstrb[DATA_W/8-1:0]}; REQ_W = 1+ADDR_W+DATA_W+DATA_W/8.
- m0_resp  out  RESP_W  ibus response {rdata[DATA_W-1:0], ready}; RESP_W = DATA_W+1.
- m1_req  in  REQ_W  dbus request, same format as m0_req.
- m1_resp  out  RESP_W  dbus response.
- s_req  out  REQ_W  merged request to the slave.
- s_resp  in  RESP_W  slave response.
- gnt  out  2  one-hot grant: bit0 = m0, bit1 = m1, 00 = none.
- busy  out  1  high while in state BUSY.

Behaviour:
- Reset:
  - state = IDLE, gnt = 00, busy = 0.
  - s_req = all zero; m0/m1 ready = 0.
  - Last-granted register = m0, so m1 wins the first round-robin tie.
- Native protocol:
  - A master holds valid and its fields stable until it sees a one-cycle ready.
  - The slave may assert ready in the same cycle as valid, or any later cycle.
- IDLE:
  - Select a master combinationally from the valid bits (arbitration below).
  - Forward the selected master's request to s_req in the same cycle; no added latency.
  - If no master is valid: s_req = 0, gnt = 00.
  - If s_resp.ready is high in that cycle: complete, stay IDLE, update last-granted.
  - Otherwise: register the selection into the grant register and go to BUSY.
- BUSY:
  - s_req is muxed from the locked grant, never from a re-arbitration.
  - On s_resp.ready: go to IDLE and update last-granted.
  - The next request is arbitrated in the cycle after ready, never in the ready cycle itself. This guarantees one idle cycle of s_req.valid between back-to-back transfers from BUSY.
- Response routing:
  - rdata is broadcast to both masters.
  - ready is gated: mX_resp.ready = s_resp.ready & gnt[X].
  - A non-granted master never sees ready.
- Fixed-priority arbitration (default): m1 (data) beats m0 (instruction) when both are valid.
- Protocol errors:
  - A granted master that drops valid before ready keeps its grant.
  - s_req.valid follows the master's valid; the state machine still waits for s_resp.ready.
  - Slave ready while gnt = 00 is ignored; no master sees it.
- Reset mid-transfer: rst forces IDLE and gnt = 00 asynchronously. The pending slave response is dropped.
- Width checks: REQ_W and RESP_W are derived locally from the parameters, with no truncation. DATA_W not divisible by 8 is a fatal elaboration error.

Optional Feature:
- Macro: IOB_CPU_BUS_ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous valid, the master not granted last wins. Last-granted updates only on completion (ready).
- Undefined: fixed priority, m1 over m0. The last-granted register is not implemented.

Decomposition:
- Shared package/header (iob bus header) holds:
  - REQ_W and RESP_W width macros.
  - Field-select macros: valid, address, wdata, wstrb, rdata, ready.
  - State encodings IDLE = 1'b0, BUSY = 1'b1.
- One sub-module: iob_cpu_bus_arb_sel. It is a combinational 2-way priority/round-robin selector with inputs valid[1:0] and last-granted, and a one-hot select output.
- The FSM, grant register and muxes stay in the top level.

Test Plan:
- Single ibus read: m0 valid, addr 0x0000_0100; slave ready 2 cycles later with rdata 0xDEADBEEF → gnt = 01 for 3 cycles; m0 ready pulses once with 0xDEADBEEF; m1 ready stays 0.
- Zero-wait transfer: m1 write to addr 0x10, wstrb 0xF, wdata 0x12345678; slave ready in the same cycle → s_req matches m1 that cycle; FSM stays IDLE; busy stays 0.
- Contention, default build: m0 and m1 both valid; slave ready after 1 cycle each → m1 served first; one idle cycle; then m0 served; the two ready pulses appear on different masters.
- Contention, RR_EN build, both held valid for 4 transfers → grants m1, m0, m1, m0. With RR_EN undefined → m1 for all 4 while m1 stays valid.
- Reset mid-BUSY: rst asserted with m0 granted and slave not ready → gnt = 00, s_req = 0 immediately; after rst release, m0 still valid → re-granted on the next cycle.
- Stray slave ready with no valid requests → both m0 and m1 ready stay 0; state stays IDLE.

Source files
------------

// File: rtl/iob_cpu_bus_arbiter_pkg.sv
// Shared iob bus definitions for the CPU bus arbiter: width helpers and FSM states.
package iob_cpu_bus_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Request: {valid, addr, wdata, wstrb}
  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response: {rdata, ready}
  function automatic int resp_w(input int data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/iob_cpu_bus_arbiter_if.sv
// iob bus bundle between the two CPU masters, the arbiter and the downstream slave.
interface iob_cpu_bus_arbiter_if
  import iob_cpu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  logic [REQ_W-1:0]  m0_req;
  logic [RESP_W-1:0] m0_resp;
  logic [REQ_W-1:0]  m1_req;
  logic [RESP_W-1:0] m1_resp;
  logic [REQ_W-1:0]  s_req;
  logic [RESP_W-1:0] s_resp;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, s_resp,
    output m0_resp, m1_resp, s_req
  );

  // Masters and memory side, as driven by the surrounding system
  modport master (
    output m0_req, m1_req, s_resp,
    input  m0_resp, m1_resp, s_req
  );
endinterface

// File: rtl/iob_cpu_bus_arb_sel.sv
// Combinational 2-way selector: fixed m1-over-m0 priority, or round-robin when
// IOB_CPU_BUS_ARB_RR_EN is defined.
module iob_cpu_bus_arb_sel (
  input  logic [1:0] valid,
`ifdef IOB_CPU_BUS_ARB_RR_EN
  input  logic       last,
`endif
  output logic [1:0] sel
);

  always_comb begin
    sel = '0;
    case (valid)
      2'b01: sel = 2'b01;
      2'b10: sel = 2'b10;
      2'b11: begin
`ifdef IOB_CPU_BUS_ARB_RR_EN
        // last = 1 means m1 was granted last, so m0 takes the tie
        sel = last ? 2'b01 : 2'b10;
`else
        sel = 2'b10;
`endif
      end
      default: sel = '0;
    endcase
  end

endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// Two-master, one-slave iob arbiter (ibus = m0, dbus = m1) with grant held until
// slave ready. Define IOB_CPU_BUS_ARB_RR_EN for round-robin tie-breaking.
module iob_cpu_bus_arbiter
  import iob_cpu_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  iob_cpu_bus_arbiter_if.slave  bus,
  output logic [1:0]            gnt,
  output logic                  busy
);

  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $fatal(1, "iob_cpu_bus_arbiter: DATA_W must be a multiple of 8");
  end

  arb_state_t state;
  logic [1:0] gnt_q;
  logic       gap_q;
  logic [1:0] valid;
  logic [1:0] sel;
  logic       s_ready;

  assign valid   = {bus.m1_req[REQ_W-1], bus.m0_req[REQ_W-1]};
  assign s_ready = bus.s_resp[0];

`ifdef IOB_CPU_BUS_ARB_RR_EN
  logic last_q;

  iob_cpu_bus_arb_sel u_sel (
    .valid (valid),
    .last  (last_q),
    .sel   (sel)
  );
`else
  iob_cpu_bus_arb_sel u_sel (
    .valid (valid),
    .sel   (sel)
  );
`endif

  // gap_q marks the cycle after a BUSY completion: the ready cycle itself never
  // re-arbitrates, and the following IDLE cycle keeps s_req quiet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt_q <= '0;
      gap_q <= 1'b0;
`ifdef IOB_CPU_BUS_ARB_RR_EN
      last_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          gap_q <= 1'b0;
          if (!gap_q && sel != 2'b00) begin
            if (s_ready) begin
`ifdef IOB_CPU_BUS_ARB_RR_EN
              last_q <= sel[1];
`endif
            end else begin
              gnt_q <= sel;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (s_ready) begin
            state <= IDLE;
            gap_q <= 1'b1;
`ifdef IOB_CPU_BUS_ARB_RR_EN
            last_q <= gnt_q[1];
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state == BUSY) gnt = gnt_q;
      else if (!gap_q)   gnt = sel;
    end
  end

  always_comb begin
    bus.s_req = '0;
    case (gnt)
      2'b01:   bus.s_req = bus.m0_req;
      2'b10:   bus.s_req = bus.m1_req;
      default: bus.s_req = '0;
    endcase
  end

  assign bus.m0_resp = {bus.s_resp[RESP_W-1:1], s_ready & gnt[0]};
  assign bus.m1_resp = {bus.s_resp[RESP_W-1:1], s_ready & gnt[1]};
  assign busy        = (state == BUSY);

endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// Scoreboard bench for iob_cpu_bus_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops them whenever a master sees ready.
module tb_iob_cpu_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;

`ifdef IOB_CPU_BUS_ARB_RR_EN
  localparam logic [1:0] CONT_FIRST  = 2'b01;
  localparam logic [1:0] CONT_SECOND = 2'b10;
  localparam logic [7:0] T4_SEQ      = {2'b01, 2'b10, 2'b01, 2'b10};
`else
  localparam logic [1:0] CONT_FIRST  = 2'b10;
  localparam logic [1:0] CONT_SECOND = 2'b01;
  localparam logic [7:0] T4_SEQ      = {2'b10, 2'b10, 2'b10, 2'b10};
`endif

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] rdata;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [REQ_W-1:0] r0, r1;
  logic [1:0] g;

  iob_cpu_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  iob_cpu_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .gnt  (gnt),
    .busy (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mkreq(input logic v, input logic [31:0] a,
                                             input logic [31:0] d, input logic [3:0] s);
    return {v, a, d, s};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.m0_resp[0] || bus.m1_resp[0])) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {bus.m1_resp[0], bus.m0_resp[0]}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_ready", {bus.m1_resp[0], bus.m0_resp[0]}, mon_e.who);
        check("resp_rdata", {bus.m1_resp[32:1], bus.m0_resp[32:1]}, {mon_e.rdata, mon_e.rdata});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.m0_req = '0;
    bus.m1_req = '0;
    bus.s_resp = '0;

    // Reset state, with a live request and slave ready present
    step();
    bus.m0_req = mkreq(1'b1, 32'h100, 32'h0, 4'h0);
    bus.s_resp = {32'h99, 1'b1};
    samp();
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_s_req", bus.s_req, '0);
    check("rst_m0_ready", bus.m0_resp[0], 1'b0);
    step();
    bus.m0_req = '0;
    bus.s_resp = '0;
    rst = 1'b0;

    // Single ibus read, slave ready two cycles later
    step();
    r0 = mkreq(1'b1, 32'h0000_0100, 32'h0, 4'h0);
    bus.m0_req = r0;
    samp();
    check("t1_gnt_c0", gnt, 2'b01);
    check("t1_s_req", bus.s_req, r0);
    check("t1_busy_c0", busy, 1'b0);
    step();
    samp();
    check("t1_gnt_c1", gnt, 2'b01);
    check("t1_busy_c1", busy, 1'b1);
    step();
    bus.s_resp = {32'hDEAD_BEEF, 1'b1};
    exp_q.push_back({2'b01, 32'hDEAD_BEEF});
    samp();
    check("t1_gnt_c2", gnt, 2'b01);
    step();
    bus.m0_req = '0;
    bus.s_resp = '0;
    samp();
    check("t1_gnt_done", gnt, 2'b00);
    check("t1_busy_done", busy, 1'b0);

    // Zero-wait dbus write
    step();
    r1 = mkreq(1'b1, 32'h10, 32'h1234_5678, 4'hF);
    bus.m1_req = r1;
    bus.s_resp = {32'h0, 1'b1};
    exp_q.push_back({2'b10, 32'h0});
    samp();
    check("t2_s_req", bus.s_req, r1);
    check("t2_gnt", gnt, 2'b10);
    check("t2_busy", busy, 1'b0);
    step();
    bus.m1_req = '0;
    bus.s_resp = '0;
    samp();
    check("t2_busy_after", busy, 1'b0);

    // Contention: both valid, one idle cycle between the two transfers
    step();
    bus.m0_req = mkreq(1'b1, 32'h200, 32'h0, 4'h0);
    bus.m1_req = mkreq(1'b1, 32'h300, 32'h0, 4'h0);
    samp();
    check("t3_first", gnt, CONT_FIRST);
    step();
    bus.s_resp = {32'h1111_1111, 1'b1};
    exp_q.push_back({CONT_FIRST, 32'h1111_1111});
    samp();
    step();
    bus.s_resp = '0;
    if (CONT_FIRST[1]) bus.m1_req = '0;
    else               bus.m0_req = '0;
    samp();
    check("t3_gap_gnt", gnt, 2'b00);
    check("t3_gap_valid", bus.s_req[REQ_W-1], 1'b0);
    step();
    samp();
    check("t3_second", gnt, CONT_SECOND);
    step();
    bus.s_resp = {32'h2222_2222, 1'b1};
    exp_q.push_back({CONT_SECOND, 32'h2222_2222});
    samp();
    step();
    bus.s_resp = '0;
    bus.m0_req = '0;
    bus.m1_req = '0;

    // Four transfers with both masters held valid, from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.m0_req = mkreq(1'b1, 32'(32'h600 + i), 32'h0, 4'h0);
      bus.m1_req = mkreq(1'b1, 32'(32'h700 + i), 32'h0, 4'h0);
      g = T4_SEQ[2*i +: 2];
      samp();
      check("t4_gnt", gnt, g);
      step();
      bus.s_resp = {32'(32'hA0 + i), 1'b1};
      exp_q.push_back({g, 32'(32'hA0 + i)});
      samp();
      step();
      bus.s_resp = '0;
      samp();
      check("t4_gap_gnt", gnt, 2'b00);
    end
    bus.m0_req = '0;
    bus.m1_req = '0;

    // Reset while BUSY with m0 granted
    step();
    r0 = mkreq(1'b1, 32'h400, 32'h0, 4'h0);
    bus.m0_req = r0;
    samp();
    check("t5_gnt_idle", gnt, 2'b01);
    step();
    samp();
    check("t5_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_gnt", gnt, 2'b00);
    check("t5_rst_s_req", bus.s_req, '0);
    check("t5_rst_busy", busy, 1'b0);
    step();
    rst = 1'b0;
    samp();
    check("t5_regrant", gnt, 2'b01);
    check("t5_regrant_req", bus.s_req, r0);
    step();
    bus.s_resp = {32'h4444_4444, 1'b1};
    exp_q.push_back({2'b01, 32'h4444_4444});
    samp();
    step();
    bus.s_resp = '0;
    bus.m0_req = '0;

    // Granted master drops valid before ready: grant is kept
    step();
    bus.m0_req = mkreq(1'b1, 32'h500, 32'h0, 4'h0);
    samp();
    check("t7_gnt", gnt, 2'b01);
    step();
    bus.m0_req = mkreq(1'b0, 32'h500, 32'h0, 4'h0);
    samp();
    check("t7_busy", busy, 1'b1);
    check("t7_gnt_kept", gnt, 2'b01);
    check("t7_s_valid", bus.s_req[REQ_W-1], 1'b0);
    step();
    bus.s_resp = {32'h77, 1'b1};
    exp_q.push_back({2'b01, 32'h77});
    samp();
    step();
    bus.s_resp = '0;
    bus.m0_req = '0;

    // Stray slave ready with no requests
    step();
    step();
    bus.s_resp = {32'h55, 1'b1};
    samp();
    check("t6_m0_ready", bus.m0_resp[0], 1'b0);
    check("t6_m1_ready", bus.m1_resp[0], 1'b0);
    check("t6_gnt", gnt, 2'b00);
    check("t6_busy", busy, 1'b0);
    step();
    bus.s_resp = '0;
    samp();
    check("t6_busy_after", busy, 1'b0);

    step();
    step();
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
